// File: rtl/wb_writer.sv
// wb_writer: write-back stage; formats load data, drives the regfile write port,
// tracks pending register writers for ID and counts retired instructions.
module wb_writer #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               mem_valid_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic               mem_is_load_i,
  input  logic [2:0]         mem_funct3_i,
  input  logic [1:0]         mem_boff_i,
  input  logic               issue_i,
  input  logic [RADDR_W-1:0] issue_rd_i,
  input  logic [RADDR_W-1:0] raddr1_i,
  input  logic [RADDR_W-1:0] raddr2_i,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_waddr_o,
  output logic [XLEN-1:0]    wb_wdata_o,
  output logic               busy1_o,
  output logic               busy2_o,
  output logic [CNT_W-1:0]   instret_o
);
  localparam int NREG = 1 << RADDR_W;
  logic [NREG-1:0] pending, set_mask, clr_mask;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] fmt;
  assign lb  = mem_wdata_i[{mem_boff_i, 3'b000} +: 8];
  assign lh  = mem_wdata_i[{mem_boff_i[1], 4'b0000} +: 16];
  assign fmt = mem_funct3_i == 3'b000 ? {{(XLEN-8){lb[7]}}, lb}
             : mem_funct3_i == 3'b001 ? {{(XLEN-16){lh[15]}}, lh}
             : mem_funct3_i == 3'b100 ? {{(XLEN-8){1'b0}}, lb}
             : mem_funct3_i == 3'b101 ? {{(XLEN-16){1'b0}}, lh}
             : mem_wdata_i;
  // set is applied after clear so a younger writer of the same rd stays pending
  assign set_mask = (issue_i && issue_rd_i != '0) ? NREG'(1) << issue_rd_i : '0;
  assign clr_mask = (wb_we_o && !stall_i) ? NREG'(1) << wb_waddr_o : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_o    <= 1'b0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
      instret_o  <= '0;
      pending    <= '0;
    end else if (flush_i) begin
      wb_we_o <= 1'b0;
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (!stall_i) begin
        wb_we_o    <= mem_valid_i & mem_we_i & (mem_waddr_i != '0);
        wb_waddr_o <= mem_waddr_i;
        wb_wdata_o <= mem_is_load_i ? fmt : mem_wdata_i;
        instret_o  <= instret_o + CNT_W'(mem_valid_i);
      end
    end
  end
  // the in-flight write is forwarded by the regfile, so it no longer counts as busy
  assign busy1_o = pending[raddr1_i] & ~(wb_we_o & (wb_waddr_o == raddr1_i));
  assign busy2_o = pending[raddr2_i] & ~(wb_we_o & (wb_waddr_o == raddr2_i));
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed vectors for wb_writer with a narrow retire counter to reach wrap.
module tb_wb_writer;
  localparam int XLEN = 32, RADDR_W = 5, CNT_W = 4;
  logic               clk = 1'b0;
  logic               rst, stall, flush, mem_valid, mem_we, mem_is_load, issue;
  logic [RADDR_W-1:0] mem_waddr, issue_rd, raddr1, raddr2;
  logic [XLEN-1:0]    mem_wdata;
  logic [2:0]         mem_funct3;
  logic [1:0]         mem_boff;
  logic               wb_we, busy1, busy2;
  logic [RADDR_W-1:0] wb_waddr;
  logic [XLEN-1:0]    wb_wdata;
  logic [CNT_W-1:0]   instret;
  int checks = 0, failures = 0;
  wb_writer #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_waddr_i(mem_waddr),
    .mem_wdata_i(mem_wdata), .mem_is_load_i(mem_is_load), .mem_funct3_i(mem_funct3),
    .mem_boff_i(mem_boff), .issue_i(issue), .issue_rd_i(issue_rd),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata),
    .busy1_o(busy1), .busy2_o(busy2), .instret_o(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {stall, flush, mem_valid, mem_we, mem_is_load, issue} = '0;
    mem_waddr = '0; mem_wdata = '0; mem_funct3 = '0; mem_boff = '0; issue_rd = '0;
  endtask
  task automatic mem(input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d,
                     input logic ld, input logic [2:0] f3, input logic [1:0] bo);
    mem_valid = 1'b1; mem_we = 1'b1; mem_waddr = rd; mem_wdata = d;
    mem_is_load = ld; mem_funct3 = f3; mem_boff = bo;
  endtask
  initial begin
    idle();
    rst = 1'b1; raddr1 = 5'd9; raddr2 = 5'd4;
    step(); step();
    rst = 1'b0;
    chk("rst_we", wb_we, 0); chk("rst_waddr", wb_waddr, 0);
    chk("rst_wdata", wb_wdata, 0); chk("rst_instret", instret, 0); chk("rst_busy1", busy1, 0);
    mem(5'd5, 32'h80FF_1234, 1'b1, 3'b000, 2'd3); step();
    chk("lb_we", wb_we, 1); chk("lb_waddr", wb_waddr, 5); chk("lb_data", wb_wdata, 32'hFFFF_FF80);
    chk("lb_ret", instret, 1);
    mem(5'd5, 32'h80FF_1234, 1'b1, 3'b100, 2'd3); step();
    chk("lbu_data", wb_wdata, 32'h0000_0080); chk("lbu_ret", instret, 2);
    mem(5'd6, 32'h80FF_1234, 1'b1, 3'b001, 2'd2); step();
    chk("lh_data", wb_wdata, 32'hFFFF_80FF); chk("lh_waddr", wb_waddr, 6);
    mem(5'd6, 32'h80FF_1234, 1'b1, 3'b101, 2'd0); step();
    chk("lhu_data", wb_wdata, 32'h0000_1234);
    mem(5'd6, 32'h80FF_1234, 1'b1, 3'b010, 2'd1); step();
    chk("lw_data", wb_wdata, 32'h80FF_1234); chk("lw_ret", instret, 5);
    mem(5'd8, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'd3); step();
    chk("alu_data", wb_wdata, 32'hDEAD_BEEF); chk("alu_ret", instret, 6);
    mem(5'd0, 32'h1111_2222, 1'b0, 3'b000, 2'd0); step();
    chk("x0_we", wb_we, 0); chk("x0_ret", instret, 7);
    mem(5'd7, 32'h0000_0077, 1'b0, 3'b000, 2'd0); step();
    chk("rd7_we", wb_we, 1); chk("rd7_waddr", wb_waddr, 7); chk("rd7_ret", instret, 8);
    mem(5'd3, 32'h0000_0033, 1'b0, 3'b000, 2'd0); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we", wb_we, 1); chk("stall_waddr", wb_waddr, 7);
      chk("stall_data", wb_wdata, 32'h77); chk("stall_ret", instret, 8);
    end
    idle(); issue = 1'b1; issue_rd = 5'd9; step();
    chk("iss9_busy1", busy1, 1); chk("iss9_we", wb_we, 0);
    mem(5'd3, 32'h0000_0033, 1'b0, 3'b000, 2'd0);
    stall = 1'b1; flush = 1'b1; issue = 1'b1; issue_rd = 5'd4; step();
    chk("flush_we", wb_we, 0); chk("flush_busy1", busy1, 0);
    chk("flush_busy2", busy2, 0); chk("flush_ret", instret, 8);
    idle(); issue = 1'b1; issue_rd = 5'd9; step();
    chk("reiss9_busy1", busy1, 1);
    idle(); mem(5'd9, 32'h99, 1'b0, 3'b000, 2'd0); step();
    chk("wb9_we", wb_we, 1); chk("wb9_busy1_fwd", busy1, 0); chk("wb9_ret", instret, 9);
    idle(); issue = 1'b1; issue_rd = 5'd9; step();
    chk("setwins_busy1", busy1, 1); chk("setwins_we", wb_we, 0);
    idle(); mem(5'd9, 32'h99, 1'b0, 3'b000, 2'd0); step();
    chk("wb9b_busy1", busy1, 0);
    idle(); step();
    chk("clr9_busy1", busy1, 0); chk("clr9_ret", instret, 10);
    raddr2 = 5'd12; issue = 1'b1; issue_rd = 5'd12; step();
    chk("iss12_busy2", busy2, 1);
    raddr1 = 5'd13; mem(5'd3, 32'h33, 1'b0, 3'b000, 2'd0);
    stall = 1'b1; issue = 1'b1; issue_rd = 5'd13; rst = 1'b1; step();
    rst = 1'b0; idle();
    chk("rst2_we", wb_we, 0); chk("rst2_waddr", wb_waddr, 0); chk("rst2_wdata", wb_wdata, 0);
    chk("rst2_ret", instret, 0); chk("rst2_busy1", busy1, 0); chk("rst2_busy2", busy2, 0);
    mem_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("ret_max", instret, 15);
    step();
    chk("ret_wrap", instret, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
